// File: rtl/pe_tile_loader.sv
// pe_tile_loader: tile load-and-issue sequencer in front of the PE array input.
// Loads N_WGT weight words and N_DATA data words from a host stream. Replays the
// data words one beat per handshake, with the weights held alongside each beat.
// Repeats this for the latched number of tiles, then pulses done.
module pe_tile_loader #(
  parameter int DATA_W = 32,
  parameter int N_DATA = 64,
  parameter int N_WGT  = 4
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     start,
  input  logic [7:0]               num_tiles,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [DATA_W-1:0]        s_data,
  output logic                     o_ivalid,
  input  logic                     o_iready,
  output logic [DATA_W-1:0]        o_data,
  output logic [N_WGT*DATA_W-1:0]  o_wgt,
  output logic                     o_first,
  output logic                     o_last,
  output logic                     busy,
  output logic                     done,
  output logic [7:0]               tile_idx
);

  // The write index is shared by the weight and data phases, so it is sized
  // for the larger of the two.
  localparam int IDX_N = (N_DATA > N_WGT) ? N_DATA : N_WGT;
  localparam int IDX_W = $clog2(IDX_N);
  localparam int RD_W  = $clog2(N_DATA);
  localparam int WG_W  = (N_WGT > 1) ? $clog2(N_WGT) : 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LD_WGT  = 3'd1,
    LD_DATA = 3'd2,
    ISSUE   = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t state;
  state_t state_nx;

  logic [IDX_W-1:0]  widx;
  logic [RD_W-1:0]   ridx;
  logic [7:0]        tile_cnt;

  logic [DATA_W-1:0] wgt      [N_WGT];
  logic [DATA_W-1:0] data_buf [N_DATA];

  logic s_hs;
  logic o_hs;
  logic wgt_end;
  logic data_end;
  logic beat_end;
  logic more_tiles;

  assign s_hs       = s_valid & s_ready;
  assign o_hs       = o_ivalid & o_iready;
  assign wgt_end    = (widx == IDX_W'(N_WGT - 1));
  assign data_end   = (widx == IDX_W'(N_DATA - 1));
  assign beat_end   = (ridx == RD_W'(N_DATA - 1));
  assign more_tiles = ({1'b0, tile_idx} + 9'd1) < {1'b0, tile_cnt};

  // State register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state decode
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = LD_WGT;
      LD_WGT:  if (s_hs && wgt_end) state_nx = LD_DATA;
      LD_DATA: if (s_hs && data_end) state_nx = ISSUE;
      ISSUE:   if (o_hs && beat_end) state_nx = more_tiles ? LD_WGT : DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs decode only from registered state and read index, so neither
  // handshake input reaches its own ready/valid combinationally.
  always_comb begin
    s_ready  = 1'b0;
    o_ivalid = 1'b0;
    o_first  = 1'b0;
    o_last   = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    case (state)
      IDLE:    busy = 1'b0;
      LD_WGT:  s_ready = 1'b1;
      LD_DATA: s_ready = 1'b1;
      ISSUE: begin
        o_ivalid = 1'b1;
        o_first  = (ridx == '0);
        o_last   = beat_end;
      end
      DONE:    done = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  // Index and tile counters; each wraps to zero exactly at its phase transition.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      widx     <= '0;
      ridx     <= '0;
      tile_idx <= 8'd0;
      tile_cnt <= 8'd1;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            widx     <= '0;
            ridx     <= '0;
            tile_idx <= 8'd0;
            tile_cnt <= (num_tiles == 8'd0) ? 8'd1 : num_tiles;
          end
        end
        LD_WGT: begin
          if (s_hs) widx <= wgt_end ? '0 : widx + IDX_W'(1);
        end
        LD_DATA: begin
          if (s_hs) begin
            widx <= data_end ? '0 : widx + IDX_W'(1);
            if (data_end) ridx <= '0;
          end
        end
        ISSUE: begin
          if (o_hs) begin
            ridx <= beat_end ? '0 : ridx + RD_W'(1);
            if (beat_end && more_tiles) tile_idx <= tile_idx + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Tile storage: written only by host handshakes, never reset.
  always_ff @(posedge clock) begin
    if (state == LD_WGT && s_hs) wgt[widx[WG_W-1:0]] <= s_data;
    if (state == LD_DATA && s_hs) data_buf[widx[RD_W-1:0]] <= s_data;
  end

  assign o_data = data_buf[ridx];

  for (genvar g = 0; g < N_WGT; g++) begin : g_wgt
    assign o_wgt[g*DATA_W +: DATA_W] = wgt[g];
  end

endmodule

// File: tb/tb_pe_tile_loader.sv
// Testbench for pe_tile_loader: table of job scenarios plus a mid-issue reset.
module tb_pe_tile_loader;

  localparam int DATA_W = 32;
  localparam int N_DATA = 64;
  localparam int N_WGT  = 4;
  localparam int WW     = N_WGT * DATA_W;
  localparam int TILE_WORDS = N_WGT + N_DATA;

  logic              clock;
  logic              resetn;
  logic              start;
  logic [7:0]        num_tiles;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              o_ivalid;
  logic              o_iready;
  logic [DATA_W-1:0] o_data;
  logic [WW-1:0]     o_wgt;
  logic              o_first;
  logic              o_last;
  logic              busy;
  logic              done;
  logic [7:0]        tile_idx;

  pe_tile_loader #(.DATA_W(DATA_W), .N_DATA(N_DATA), .N_WGT(N_WGT)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .start     (start),
    .num_tiles (num_tiles),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .o_ivalid  (o_ivalid),
    .o_iready  (o_iready),
    .o_data    (o_data),
    .o_wgt     (o_wgt),
    .o_first   (o_first),
    .o_last    (o_last),
    .busy      (busy),
    .done      (done),
    .tile_idx  (tile_idx)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    int nt;          // num_tiles driven at start
    bit stall;       // randomise o_iready
    bit gap;         // gap s_valid
    bit poke;        // pulse start / change num_tiles mid-job
    int exp_tiles;   // tiles expected to issue
    int exp_cycles;  // first LD_WGT cycle to done cycle inclusive (0 = skip)
    int base;        // data/weight value offset
    int abort_beat;  // reset at this beat (-1 = none)
  } vec_t;

  vec_t vecs [8];

  function automatic logic [DATA_W-1:0] wval(input int base, input int t, input int w);
    return DATA_W'(base + t * 16 + w + 1);
  endfunction

  function automatic logic [DATA_W-1:0] dval(input int base, input int t, input int i);
    return DATA_W'(base + 100 + 1000 * t + i);
  endfunction

  function automatic logic [WW-1:0] wpack(input int base, input int t);
    logic [WW-1:0] p;
    p = '0;
    for (int w = 0; w < N_WGT; w++) p[w*DATA_W +: DATA_W] = wval(base, t, w);
    return p;
  endfunction

  function automatic logic [DATA_W-1:0] host_word(input int base, input int k);
    int t;
    int j;
    t = k / TILE_WORDS;
    j = k % TILE_WORDS;
    if (j < N_WGT) return wval(base, t, j);
    return dval(base, t, j - N_WGT);
  endfunction

  task automatic reset_checks(input string tag);
    chk({tag, "_s_ready"},  WW'(s_ready),  WW'(0));
    chk({tag, "_o_ivalid"}, WW'(o_ivalid), WW'(0));
    chk({tag, "_o_first"},  WW'(o_first),  WW'(0));
    chk({tag, "_o_last"},   WW'(o_last),   WW'(0));
    chk({tag, "_busy"},     WW'(busy),     WW'(0));
    chk({tag, "_done"},     WW'(done),     WW'(0));
    chk({tag, "_tile_idx"}, WW'(tile_idx), WW'(0));
  endtask

  task automatic run_job(input int n, input vec_t v);
    int cyc;
    int sent;
    int beats;
    int dones;
    int done_cyc;
    int total;
    int limit;
    int t;
    int i;
    bit finished;
    bit aborted;
    string tg;
    tg = $sformatf("v%0d", n);
    sent = 0; beats = 0; dones = 0; done_cyc = 0;
    finished = 0; aborted = 0;
    total = v.exp_tiles * TILE_WORDS;
    limit = v.exp_tiles * (TILE_WORDS + N_DATA) * 4 + 100;

    @(negedge clock);
    num_tiles = 8'(v.nt);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    if (v.poke) num_tiles = 8'd9;
    cyc = 1;

    while (!finished && cyc <= limit) begin
      if (done) begin
        dones++;
        done_cyc = cyc;
        finished = 1;
        chk({tag_s(tg), "_busy_at_done"}, WW'(busy), WW'(1));
      end else begin
        o_iready = v.stall ? ($urandom_range(0, 1) == 1) : 1'b1;
        if (o_ivalid) begin
          t = beats / N_DATA;
          i = beats % N_DATA;
          if (v.abort_beat >= 0 && beats == v.abort_beat) begin
            resetn = 1'b0;
            #1;
            reset_checks({tg, "_abort"});
            repeat (3) begin
              @(negedge clock);
              chk({tg, "_abort_no_done"}, WW'(done), WW'(0));
            end
            resetn = 1'b1;
            aborted = 1;
            finished = 1;
          end else begin
            chk($sformatf("%s_data_b%0d", tg, beats), WW'(o_data), WW'(dval(v.base, t, i)));
            chk($sformatf("%s_first_b%0d", tg, beats), WW'(o_first), WW'(i == 0));
            chk($sformatf("%s_last_b%0d", tg, beats), WW'(o_last), WW'(i == N_DATA - 1));
            chk($sformatf("%s_wgt_b%0d", tg, beats), o_wgt, wpack(v.base, t));
            chk($sformatf("%s_tile_b%0d", tg, beats), WW'(tile_idx), WW'(t));
            if (o_iready) beats++;
          end
        end
        if (!aborted) begin
          if (sent < total && !(v.gap && $urandom_range(0, 2) == 0)) begin
            s_valid = 1'b1;
            s_data  = host_word(v.base, sent);
          end else begin
            s_valid = 1'b0;
            s_data  = $urandom;
          end
          if (s_valid && s_ready) sent++;
          if (v.poke) start = (cyc == 20 || cyc == 100);
          @(negedge clock);
          cyc++;
        end
      end
    end
    start    = 1'b0;
    s_valid  = 1'b0;
    o_iready = 1'b0;

    if (aborted) return;
    chk({tg, "_job_ended"}, WW'(finished), WW'(1));
    chk({tg, "_beats"}, WW'(beats), WW'(v.exp_tiles * N_DATA));
    chk({tg, "_words"}, WW'(sent), WW'(total));
    if (v.exp_cycles != 0) chk({tg, "_cycles"}, WW'(done_cyc), WW'(v.exp_cycles));
    chk({tg, "_tile_final"}, WW'(tile_idx), WW'(v.exp_tiles - 1));
    @(negedge clock);
    chk({tg, "_done_one_cycle"}, WW'(done), WW'(0));
    chk({tg, "_busy_after"}, WW'(busy), WW'(0));
    chk({tg, "_tile_hold"}, WW'(tile_idx), WW'(v.exp_tiles - 1));
  endtask

  function automatic string tag_s(input string s);
    return s;
  endfunction

  initial begin
    //           nt stl gap pok tiles cycles base abort
    vecs[0] = '{1, 0, 0, 0, 1, 133, 0,    -1};
    vecs[1] = '{1, 1, 1, 0, 1, 0,   0,    -1};
    vecs[2] = '{3, 0, 0, 0, 3, 397, 0,    -1};
    vecs[3] = '{0, 0, 0, 0, 1, 133, 200,  -1};
    vecs[4] = '{1, 0, 0, 1, 1, 133, 0,    -1};
    vecs[5] = '{2, 1, 1, 0, 2, 0,   300,  -1};
    vecs[6] = '{1, 0, 0, 0, 1, 0,   0,    10};
    vecs[7] = '{1, 0, 0, 0, 1, 133, 5000, -1};

    resetn    = 1'b0;
    start     = 1'b0;
    num_tiles = 8'd0;
    s_valid   = 1'b0;
    s_data    = '0;
    o_iready  = 1'b0;
    repeat (2) @(negedge clock);
    reset_checks("rst");
    resetn = 1'b1;
    @(negedge clock);
    s_valid = 1'b1;
    #1;
    chk("idle_s_ready", WW'(s_ready), WW'(0));
    s_valid = 1'b0;

    for (int n = 0; n < 8; n++) run_job(n, vecs[n]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pe_tile_loader.md
# pe_tile_loader

Tile load-and-issue controller in front of the PE array input port. Accepts a tile from a host word stream: N_WGT weight words, then N_DATA data words. Buffers the tile locally, then replays the data words to the PE array one beat per accepted handshake, with the weights held stable alongside every beat. Repeats for a programmed number of tiles, replacing the hand-driven stimulus path into `pe_array_input_t` with a synthesizable sequencer.

## Interface
Parameters:
- DATA_W, 32, width of one host/data/weight word
- N_DATA, 64, data words per tile (power of two, ≥2)
- N_WGT, 4, weight words per tile (power of two, ≥1)

Ports:
- clock  in  1  single clock; all state updates on rising edge
- resetn  in  1  reset, asynchronous assert, active-low
- start  in  1  begin a job; sampled only in IDLE
- num_tiles  in  8  tiles per job, latched on accepted start; 0 treated as 1
- s_valid  in  1  host word valid
- s_ready  out  1  loader accepts host word
- s_data  in  DATA_W  host word
- o_ivalid  out  1  beat valid to PE array
- o_iready  in  1  PE array accepts beat
- o_data  out  DATA_W  current data word
- o_wgt  out  N_WGT*DATA_W  tile weights, word 0 in LSBs
- o_first  out  1  beat is data word 0 of tile
- o_last  out  1  beat is data word N_DATA-1 of tile
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at job end
- tile_idx  out  8  index of tile currently loading or issuing

## Operation
- States: IDLE, LD_WGT, LD_DATA, ISSUE, DONE.
- IDLE: s_ready=0, o_ivalid=0. start=1 → LD_WGT, tile_idx=0, num_tiles latched (0→1).
- LD_WGT: s_ready=1. Each s_valid&s_ready writes s_data to wgt[widx], widx++. Accepting word N_WGT-1 → LD_DATA, widx=0.
- LD_DATA: s_ready=1. Each handshake writes buf[widx], widx++. Accepting word N_DATA-1 → ISSUE, widx=0, ridx=0.
- ISSUE: s_ready=0, o_ivalid=1, o_data=buf[ridx], o_first=(ridx==0), o_last=(ridx==N_DATA-1). ridx advances only on o_ivalid&o_iready.
  - Last beat accepted with tile_idx+1 < latched count → LD_WGT, tile_idx++.
  - Otherwise → DONE.
- DONE: done=1 for exactly one cycle, then IDLE. tile_idx holds its final value until the next start.
- o_wgt reflects wgt registers. It changes only during LD_WGT, so it is stable for all ISSUE beats.
- start outside IDLE is ignored. Host words outside LD_WGT/LD_DATA are not accepted (s_ready=0).
- Counters use log2 widths and wrap to 0 exactly at the state transition, never by overflow.
- No combinational path from o_iready to o_ivalid/o_data/o_first/o_last, or from s_valid to s_ready.
  - All outputs decode from registered state and indices only.

## Timing
- Reset: state=IDLE, widx=ridx=0, tile_idx=0, s_ready=0, o_ivalid=0, o_first=0, o_last=0, busy=0, done=0.
  - o_wgt and o_data are not reset.
  - buf is never presented before being written.
- Reset mid-operation aborts immediately: no done pulse; the partial tile is discarded.
- Start accepted in cycle T → s_ready=1 in T+1.
- Last data word accepted in cycle T → first o_ivalid in T+1.
- Last beat of final tile accepted in T → done=1 in T+1, busy=0 in T+2.
- With s_valid and o_iready held high, one tile takes N_WGT+N_DATA+N_DATA cycles (132 at defaults).
  - Job time is num_tiles×132+1 cycles from the first LD_WGT cycle to the done cycle inclusive.
- o_iready low stalls ISSUE indefinitely; outputs hold constant.
- s_valid low stalls loading indefinitely.

## Test plan
- Single tile: start, num_tiles=1, host sends weights 1..4 then data 100..163, o_iready=1 → 64 beats with o_data=100..163, o_wgt={4,3,2,1}, o_first on beat 0, o_last on beat 63, done 133 cycles after first LD_WGT cycle.
- Backpressure: o_iready toggled randomly, s_valid gapped → beat sequence identical to the single-tile case, no duplicated or dropped words, outputs stable while stalled.
- Multi-tile: num_tiles=3, distinct weights/data per tile → tile_idx 0,1,2, o_wgt updates only between tiles, one done pulse at end. num_tiles=0 behaves as 1.
- Start ignored: pulse start during LD_DATA and ISSUE → no effect on counters or sequence.
- Reset mid-ISSUE at beat 10: resetn low → all outputs reset values immediately, no done. A new job afterward issues fresh data correctly.
